// File: rtl/wordle_board.sv
// Wordle game-state engine: 6x5 guess grid, key entry, duplicate-aware scoring,
// win/lose tracking and a registered tile read port for the VGA renderer.
module wordle_board #(
  parameter int ROWS = 6,
  parameter int COLS = 5
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        new_game,
  input  logic [24:0] target,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  input  logic        key_back,
  input  logic        key_enter,
  output logic [24:0] cur_word,
  input  logic        cur_in_db,
  input  logic [2:0]  rd_row,
  input  logic [2:0]  rd_col,
  output logic [4:0]  rd_letter,
  output logic        rd_filled,
  output logic [1:0]  rd_status,
  output logic [2:0]  cur_row,
  output logic [2:0]  cur_col,
  output logic        busy,
  output logic        reject,
  output logic        won,
  output logic        lost,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_PLAY    = 3'd0;
  localparam logic [2:0] S_SCORE_G = 3'd1;
  localparam logic [2:0] S_SCORE_Y = 3'd2;
  localparam logic [2:0] S_COMMIT  = 3'd3;
  localparam logic [2:0] S_WON     = 3'd4;
  localparam logic [2:0] S_LOST    = 3'd5;

  localparam logic [2:0] NROW     = 3'(ROWS);
  localparam logic [2:0] NCOL     = 3'(COLS);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  logic [4:0] letter_q [ROWS][COLS];
  logic       filled_q [ROWS][COLS];
  logic [1:0] status_q [ROWS][COLS];

  logic [2:0]  state_q, state_d;
  logic [2:0]  cur_row_q, cur_row_d;
  logic [2:0]  cur_col_q, cur_col_d;
  logic        reject_q, reject_d;
  logic [24:0] tgt_q;
  logic [COLS-1:0] green_q, used_q, yellow_q;
  logic [2:0]  yc_q;
  logic [4:0]  rd_letter_q;
  logic        rd_filled_q;
  logic [1:0]  rd_status_q;

  logic       tile_we, tile_fill, score_start;
  logic [2:0] tile_col;
  logic [4:0] tile_letter;
  logic [4:0] guess_y;
  logic       hit;
  logic [2:0] hit_p;

  always_comb begin
    state_d     = state_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    reject_d    = 1'b0;
    tile_we     = 1'b0;
    tile_col    = cur_col_q;
    tile_letter = 5'd0;
    tile_fill   = 1'b0;
    score_start = 1'b0;
    case (state_q)
      S_PLAY: begin
        if (key_enter) begin
          if (cur_col_q == NCOL) begin
            if (cur_in_db) begin
              state_d     = S_SCORE_G;
              score_start = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end
        end else if (key_back) begin
          if (cur_col_q != 3'd0) begin
            tile_we   = 1'b1;
            tile_col  = cur_col_q - 3'd1;
            cur_col_d = cur_col_q - 3'd1;
          end
        end else if (key_valid && key_code < 5'd26 && cur_col_q < NCOL) begin
          tile_we     = 1'b1;
          tile_letter = key_code;
          tile_fill   = 1'b1;
          cur_col_d   = cur_col_q + 3'd1;
        end
      end
      S_SCORE_G: state_d = S_SCORE_Y;
      S_SCORE_Y: if (yc_q == NCOL - 3'd1) state_d = S_COMMIT;
      S_COMMIT: begin
        if (&green_q) begin
          state_d = S_WON;
        end else if (cur_row_q == LAST_ROW) begin
          state_d   = S_LOST;
          cur_row_d = NROW;
        end else begin
          state_d   = S_PLAY;
          cur_row_d = cur_row_q + 3'd1;
          cur_col_d = 3'd0;
        end
      end
      default: ;
    endcase
  end

  // Lowest unused target position matching the guess letter under scan.
  always_comb begin
    guess_y = letter_q[cur_row_q][yc_q];
    hit     = 1'b0;
    hit_p   = 3'd0;
    for (int p = COLS - 1; p >= 0; p--) begin
      if (!used_q[p] && tgt_q[5*p +: 5] == guess_y) begin
        hit   = 1'b1;
        hit_p = 3'(p);
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (clr || new_game) begin
      state_q     <= S_PLAY;
      cur_row_q   <= 3'd0;
      cur_col_q   <= 3'd0;
      reject_q    <= 1'b0;
      tgt_q       <= '0;
      green_q     <= '0;
      used_q      <= '0;
      yellow_q    <= '0;
      yc_q        <= 3'd0;
      rd_letter_q <= 5'd0;
      rd_filled_q <= 1'b0;
      rd_status_q <= 2'd0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          letter_q[r][c] <= 5'd0;
          filled_q[r][c] <= 1'b0;
          status_q[r][c] <= 2'd0;
        end
      end
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      reject_q  <= reject_d;
      if (tile_we) begin
        letter_q[cur_row_q][tile_col] <= tile_letter;
        filled_q[cur_row_q][tile_col] <= tile_fill;
      end
      if (score_start) tgt_q <= target;
      case (state_q)
        S_SCORE_G: begin
          for (int c = 0; c < COLS; c++) begin
            green_q[c] <= (letter_q[cur_row_q][c] == tgt_q[5*c +: 5]);
            used_q[c]  <= (letter_q[cur_row_q][c] == tgt_q[5*c +: 5]);
          end
          yellow_q <= '0;
          yc_q     <= 3'd0;
        end
        S_SCORE_Y: begin
          if (!green_q[yc_q] && hit) begin
            used_q[hit_p]  <= 1'b1;
            yellow_q[yc_q] <= 1'b1;
          end
          yc_q <= yc_q + 3'd1;
        end
        S_COMMIT: begin
          for (int c = 0; c < COLS; c++)
            status_q[cur_row_q][c] <= green_q[c] ? 2'd3 : (yellow_q[c] ? 2'd2 : 2'd1);
        end
        default: ;
      endcase
      if (rd_row < NROW && rd_col < NCOL) begin
        rd_letter_q <= letter_q[rd_row][rd_col];
        rd_filled_q <= filled_q[rd_row][rd_col];
        rd_status_q <= status_q[rd_row][rd_col];
      end else begin
        rd_letter_q <= 5'd0;
        rd_filled_q <= 1'b0;
        rd_status_q <= 2'd0;
      end
    end
  end

  always_comb begin
    cur_word = '0;
    if (cur_row_q < NROW)
      for (int c = 0; c < COLS; c++) cur_word[5*c +: 5] = letter_q[cur_row_q][c];
  end

  assign rd_letter = rd_letter_q;
  assign rd_filled = rd_filled_q;
  assign rd_status = rd_status_q;
  assign cur_row   = cur_row_q;
  assign cur_col   = cur_col_q;
  assign busy      = (state_q == S_SCORE_G) || (state_q == S_SCORE_Y) || (state_q == S_COMMIT);
  assign reject    = reject_q;
  assign won       = (state_q == S_WON);
  assign lost      = (state_q == S_LOST);
  assign dbg_state = state_q;

endmodule

// File: doc/wordle_board.md
Name: wordle_board

Overview:
- Game-state engine sitting directly upstream of the 640x480 VGA renderer.
- Holds the 6x5 guess grid (letter plus per-tile colour status) and accepts decoded key events.
- Scores each submitted guess against the target word using Wordle duplicate-letter rules, tracks win/lose.
- Serves a registered pixel-side read port so the renderer can look up the tile under the current box_i/box_j.

Parameters:
- ROWS, 6, number of guess rows
- COLS, 5, letters per guess (fixed by word packing; no other value supported)

Ports:
- dclk  in  1  system clock (same domain as renderer)
- clr  in  1  reset, synchronous, active-high
- new_game  in  1  1-cycle pulse: clear board, return to PLAY (same effect as clr)
- target  in  25  answer word; letter c at [5c+4:5c], 0=A..25=Z; sampled at enter acceptance
- key_valid  in  1  letter key strobe
- key_code  in  5  letter 0..25, qualified by key_valid; values 26..31 are ignored
- key_back  in  1  backspace strobe
- key_enter  in  1  submit strobe
- cur_word  out  25  letters of the current row, same packing as target; unfilled columns read 0
- cur_in_db  in  1  dictionary result for cur_word (combinational from word_db)
- rd_row  in  3  renderer read row
- rd_col  in  3  renderer read column
- rd_letter  out  5  letter at (rd_row, rd_col)
- rd_filled  out  1  tile holds a letter
- rd_status  out  2  0 unscored, 1 grey, 2 yellow, 3 green
- cur_row  out  3  active row 0..6
- cur_col  out  3  next free column 0..5
- busy  out  1  scoring in progress
- reject  out  1  1-cycle pulse: full row not in dictionary
- won  out  1  level, sticky until clr/new_game
- lost  out  1  level, sticky until clr/new_game

Behaviour:
- Reset (clr or new_game, evaluated at dclk edge):
  - All letters, filled flags and statuses cleared; cur_row=0, cur_col=0.
  - busy=0, reject=0, won=0, lost=0; rd_* outputs 0 on the next cycle.
  - State=PLAY.
  - clr or new_game during scoring aborts scoring immediately.
- States: PLAY, SCORE_G, SCORE_Y, COMMIT, WON, LOST.
- PLAY, one key action per cycle, priority key_enter > key_back > key_valid:
  - Letter with cur_col<5: write (cur_row, cur_col), set filled, cur_col+1. Ignored at cur_col=5.
  - Back with cur_col>0: clear (cur_row, cur_col-1), cur_col-1. Ignored at cur_col=0.
  - Enter with cur_col<5: ignored, no reject.
  - Enter with cur_col=5 and cur_in_db=0: reject=1 for exactly that next cycle; board unchanged.
  - Enter with cur_col=5 and cur_in_db=1: latch target into an internal copy, go to SCORE_G, busy=1.
- SCORE_G (1 cycle):
  - green[c] = guess[c]==tgt[c].
  - Target position c is marked used where green.
- SCORE_Y (5 cycles, c=0..4 in order):
  - If not green[c] and some unused target position p has tgt[p]==guess[c], choose the lowest such p, mark it used, yellow[c]=1.
  - Otherwise the column stays grey.
- COMMIT (1 cycle): write statuses for the row.
  - All green -> WON.
  - Else if cur_row=5 -> LOST with cur_row=6.
  - Else cur_row+1, cur_col=0, PLAY.
  - busy deasserts on the next cycle.
- Latency: enter accepted at edge T -> statuses visible on the read port from T+8. busy is high for cycles T+1..T+7.
- Key strobes are ignored in all states except PLAY, including during busy, WON and LOST.
- Read port:
  - Registered, 1-cycle latency; valid in every state.
  - rd_row>=6 or rd_col>=5 returns letter 0, filled 0, status 0.
- Unscored rows, and the active row until COMMIT, report status 0.
- won/lost are levels, never both 1.

Test Plan:
- Reset then type C,R,A,N,E, enter with cur_in_db=1, target=CRANE -> cur_col=5 before enter, busy for 7 cycles, all rd_status=3, won=1, further keys ignored.
- Target=ABBEY, guess BABES -> statuses row0: yellow, yellow, green, green, grey (2,2,3,3,1).
- Target=CRANE, guess EERIE -> statuses grey, grey, yellow, grey, green (1,1,2,1,3): duplicate E yields no extra yellow.
- Full row with cur_in_db=0, enter -> reject pulse of exactly 1 cycle, cur_row stays 0, statuses stay 0; then back -> cur_col=4, tile (0,4) filled=0.
- Six wrong valid guesses -> lost=1, cur_row=6, won=0; new_game pulse -> all outputs back to reset values.
- Edge cases:
  - key_back at cur_col=0 -> no change.
  - Sixth letter -> no change.
  - key_enter and key_valid asserted together on a full row -> scoring starts, letter dropped.
  - clr asserted mid SCORE_Y -> board cleared, busy=0 next cycle.
